cover_toggle_sink: RTL and testbench
====================================

// Module: cover_toggle_sink
// PURPOSE
//  Receiving end of the toggle-coverage event interface. Accepts the per-lane
//  valid strobes that a toggle cover generator raises, and de-duplicates them
//  with a sticky "seen" bitmap. Each first hit is serialized as one absolute
//  cover index on a valid/ready stream toward the coverage DMA/readout.
//  Also keeps a distinct-hit count and an all-hit flag for on-chip status.
// PARAMETERS
//  LANES        4      number of cover lanes (1..64); lane i = point COVER_INDEX+i
//  COVER_INDEX  0      absolute index of lane 0
//  COVER_TOTAL  10906  global cover-point total; out_index < COVER_TOTAL required
//  CNT_W        16     width of hit_count (saturating)
// PORTS
//  clock        in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  valid        in   LANES  per-lane toggle event strobe, sampled every cycle
//  clear        in   1      1-cycle pulse: restart coverage collection
//  out_valid    out  1      out_index holds a first-hit cover index
//  out_ready    in   1      consumer accepts out_index when out_valid&&out_ready
//  out_index    out  64     absolute cover index (matches longint cover_index)
//  hit_count    out  CNT_W  number of distinct lanes seen since reset/clear
//  all_hit      out  1      1 when every lane has been seen
// BEHAVIOUR
//  Reset (reset=1 at posedge): seen=0, pending=0, out_valid=0, out_index=0,
//   hit_count=0, all_hit=0. reset overrides clear, valid and out_ready.
//  Capture, each posedge with reset=0, clear=0:
//   newhit = valid & ~seen; seen |= valid; pending |= newhit;
//   hit_count += popcount(newhit), saturating at 2^CNT_W-1.
//   Repeat hits on a seen lane are dropped silently (never re-reported).
//  Output stage, 2 states: IDLE (out_valid=0) / HOLD (out_valid=1).
//   load condition: IDLE, or HOLD with out_ready=1.
//   On load, if pending (register value before this edge's capture) != 0:
//   i = lowest set bit; out_index <= COVER_INDEX+i; pending[i] cleared;
//   -> HOLD. If pending==0: out_valid <= 0 -> IDLE.
//   A new hit and a load on the same lane in the same edge cannot conflict:
//   a lane only enters pending while unseen and only once.
//   In HOLD with out_ready=0: out_index and out_valid stay stable.
//  Latency: valid[i] at edge E0 (first hit) -> out_valid=1 after E1, if the
//   output stage is free and no lower lane is pending. Throughput is 1 index
//   per cycle while out_ready=1.
//  Ordering: among lanes pending together, ascending lane order.
//  clear=1 (reset=0): seen, pending and hit_count go to 0. valid in the same
//   cycle is dropped (clear wins). An index already in HOLD is NOT dropped:
//   it stays until accepted. No load occurs on the clear edge.
//  all_hit = &seen, registered (same edge as seen); cleared by clear/reset.
//  Width: out_index is zero-extended COVER_INDEX+i computed in 64 bits.
//  No overflow is possible: pending is bounded by LANES, so there is no FIFO.
// TESTING
//  T1 reset, valid=4'b0100 one cycle, out_ready=1 -> 2 cycles later
//     out_valid=1 for 1 cycle, out_index=COVER_INDEX+2, hit_count=1.
//  T2 valid=4'b1111 one cycle, out_ready=1 -> indices +0,+1,+2,+3 on 4
//     consecutive cycles, hit_count=4, all_hit=1.
//  T3 valid=4'b0001 repeated 10 cycles -> exactly one out transfer (+0),
//     hit_count=1.
//  T4 out_ready=0, valid=4'b1010 -> out_index=+1 held stable for 5 cycles.
//     Raising out_ready -> +1 then +3 transferred.
//  T5 out_index=+1 in HOLD, pulse clear with valid=4'b0001 -> +1 still
//     delivered, +0 never reported, hit_count=0. Then valid=4'b0010 ->
//     +1 reported again.
//  T6 reset asserted mid-HOLD with pending lanes -> next cycle out_valid=0,
//     hit_count=0, all_hit=0, no further indices until new valid.

Source files
------------

// File: rtl/cover_toggle_sink.sv
// cover_toggle_sink: de-duplicates toggle cover strobes and streams first-hit cover indices
module cover_toggle_sink #(
    parameter int              LANES       = 4,
    parameter longint unsigned COVER_INDEX = 0,
    parameter longint unsigned COVER_TOTAL = 10906,
    parameter int              CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LANES-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_hit
);
    localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
    localparam int SW = CNT_W + 8;
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [LANES-1:0] seen, pending, newhit, take;
    logic [IDX_W-1:0] low_idx;
    logic [6:0] inc;
    logic [SW-1:0] sum;
    logic [63:0] index_n;
    logic load;
    always_comb begin
        newhit = valid & ~seen;
        low_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) low_idx = pending[k] ? IDX_W'(k) : low_idx;
        inc = '0;
        for (int k = 0; k < LANES; k++) inc = inc + 7'(newhit[k]);
        sum = SW'(hit_count) + SW'(inc);
        load = !clear && (state == IDLE || out_ready);
        take = '0;
        state_n = state;
        index_n = out_index;
        if (load) begin
            state_n = |pending ? HOLD : IDLE;
            index_n = |pending ? COVER_INDEX + 64'(low_idx) : out_index;
            take[low_idx] = |pending;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            out_index <= '0;
            seen      <= '0;
            pending   <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
        end else begin
            state     <= state_n;
            out_index <= index_n;
            seen      <= clear ? '0 : seen | valid;
            pending   <= clear ? '0 : (pending & ~take) | newhit;
            hit_count <= clear ? '0 : (sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0]);
            all_hit   <= clear ? 1'b0 : &(seen | valid);
        end
    end
    assign out_valid = state == HOLD;
    assert property (@(posedge clock) disable iff (reset) out_valid |-> out_index < COVER_TOTAL);
endmodule

// File: tb/tb_cover_toggle_sink.sv
// tb_cover_toggle_sink: directed checks of first-hit streaming, holding, clear and reset
module tb_cover_toggle_sink;
    logic clock = 0, reset = 1, clear = 0, out_ready = 1;
    logic [3:0] valid = '0;
    logic out_valid, all_hit, out_valid2, all_hit2;
    logic [63:0] out_index, out_index2;
    logic [15:0] hit_count;
    logic [1:0] hit_count2;
    int n_cmp = 0, n_bad = 0;
    longint got[$];

    always #5 clock = ~clock;

    cover_toggle_sink dut (
        .clock(clock), .reset(reset), .valid(valid), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .hit_count(hit_count), .all_hit(all_hit)
    );

    cover_toggle_sink #(.LANES(4), .COVER_INDEX(10900), .COVER_TOTAL(10906), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .valid(valid), .clear(clear),
        .out_valid(out_valid2), .out_ready(out_ready), .out_index(out_index2),
        .hit_count(hit_count2), .all_hit(all_hit2)
    );

    always @(negedge clock) if (!reset && out_valid && out_ready) got.push_back(longint'(out_index));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; valid = '0; clear = 0;
        step(2);
        reset = 0;
        got.delete();
    endtask

    initial begin
        // T1: single lane, latency and one-cycle transfer
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_index", out_index, 0);
        check("rst_count", hit_count, 0);
        check("rst_allhit", all_hit, 0);
        out_ready = 1; valid = 4'b0100;
        step();
        valid = '0;
        check("t1_count", hit_count, 1);
        check("t1_not_yet", out_valid, 0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_index", out_index, 2);
        step();
        check("t1_drop", out_valid, 0);
        check("t1_nxfer", got.size(), 1);
        // T2: all lanes together, ascending order, saturation on narrow counter
        do_reset();
        valid = 4'b1111;
        step();
        valid = '0;
        check("t2_count", hit_count, 4);
        check("t2_allhit", all_hit, 1);
        check("t2_sat_count", hit_count2, 3);
        check("t2_allhit2", all_hit2, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_valid", out_valid, 1);
            check("t2_index", out_index, i);
            check("t2_index_off", out_index2, 10900 + i);
        end
        step();
        check("t2_idle", out_valid, 0);
        check("t2_nxfer", got.size(), 4);
        // T3: repeated hits on one lane reported once
        do_reset();
        valid = 4'b0001;
        step(10);
        valid = '0;
        step(3);
        check("t3_nxfer", got.size(), 1);
        if (got.size() > 0) check("t3_index", got[0], 0);
        check("t3_count", hit_count, 1);
        // T4: backpressure holds index stable
        do_reset();
        out_ready = 0; valid = 4'b1010;
        step();
        valid = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_index", out_index, 1);
            step();
        end
        out_ready = 1;
        step();
        check("t4_next", out_index, 3);
        check("t4_next_valid", out_valid, 1);
        step();
        check("t4_idle", out_valid, 0);
        check("t4_nxfer", got.size(), 2);
        if (got.size() == 2) check("t4_second", got[1], 3);
        // T5: clear keeps held index, drops same-cycle hit
        do_reset();
        out_ready = 0; valid = 4'b0010;
        step();
        valid = '0;
        step();
        clear = 1; valid = 4'b0001;
        step();
        clear = 0; valid = '0;
        check("t5_count", hit_count, 0);
        check("t5_hold", out_valid, 1);
        check("t5_index", out_index, 1);
        out_ready = 1;
        step();
        check("t5_idle", out_valid, 0);
        step(3);
        check("t5_nxfer", got.size(), 1);
        valid = 4'b0010;
        step();
        valid = '0;
        step();
        check("t5_again_valid", out_valid, 1);
        check("t5_again_index", out_index, 1);
        step();
        check("t5_nxfer2", got.size(), 2);
        check("t5_count2", hit_count, 1);
        // T6: reset mid-hold discards pending lanes
        do_reset();
        out_ready = 0; valid = 4'b1111;
        step();
        valid = '0;
        step();
        check("t6_hold", out_valid, 1);
        reset = 1;
        step();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_count", hit_count, 0);
        check("t6_rst_allhit", all_hit, 0);
        reset = 0; out_ready = 1;
        step(4);
        check("t6_quiet", out_valid, 0);
        check("t6_nxfer", got.size(), 0);
        valid = 4'b1000;
        step();
        valid = '0;
        step();
        check("t6_new_valid", out_valid, 1);
        check("t6_new_index", out_index, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
